// File: rtl/cpu_8bit_pkg.sv
// Shared types for the 8-bit CPU control path: opcodes, sequencer states and the
// control word with its all-inactive value.
package cpu_8bit_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_LDB = 4'h2,
        OP_STA = 4'h3,
        OP_ALU = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_JC  = 4'h7,
        OP_JN  = 4'h8,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH0, S_FETCH1, S_DECODE,
        S_ADR0, S_ADR1, S_MEMA, S_MEMB, S_STA,
        S_ALU, S_JA0, S_JA1, S_SKIP, S_HALT
    } seq_state_e;

    typedef struct packed {
        logic       a_wrtn;
        logic       b_wrtn;
        logic       ir_wrtn;
        logic       mar_wrtn;
        logic       a_rdn;
        logic       b_rdn;
        logic       ir_rdn;
        logic       mar_rdn;
        logic       mem_rdn;
        logic       mem_wrtn;
        logic       alu_sel;
        logic       alu_flag_sel;
        logic [3:0] alu_opcode;
        logic       cin;
        logic       pc_cntn;
        logic       pc_den;
        logic       pc_din;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        a_wrtn: 1'b1, b_wrtn: 1'b1, ir_wrtn: 1'b1, mar_wrtn: 1'b1,
        a_rdn: 1'b1, b_rdn: 1'b1, ir_rdn: 1'b1, mar_rdn: 1'b1,
        mem_rdn: 1'b1, mem_wrtn: 1'b1,
        alu_sel: 1'b0, alu_flag_sel: 1'b0, alu_opcode: 4'd0, cin: 1'b0,
        pc_cntn: 1'b1, pc_den: 1'b0, pc_din: 1'b0
    };

endpackage

// File: rtl/seq_decode.sv
// Combinational microcode ROM: maps the sequencer state (and latched ALU operand)
// to the datapath control word.
module seq_decode
    import cpu_8bit_pkg::*;
(
    input  seq_state_e state_i,
    input  logic [3:0] operand_i,
    output ctrl_word_t ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        unique case (state_i)
            S_FETCH0, S_ADR0, S_JA0: begin
                ctrl_o.pc_den   = 1'b1;
                ctrl_o.mar_wrtn = 1'b0;
            end
            S_FETCH1: begin
                ctrl_o.mem_rdn = 1'b0;
                ctrl_o.ir_wrtn = 1'b0;
                ctrl_o.pc_cntn = 1'b0;
            end
            S_ADR1: begin
                ctrl_o.mem_rdn  = 1'b0;
                ctrl_o.mar_wrtn = 1'b0;
                ctrl_o.pc_cntn  = 1'b0;
            end
            S_MEMA: begin
                ctrl_o.mem_rdn = 1'b0;
                ctrl_o.a_wrtn  = 1'b0;
            end
            S_MEMB: begin
                ctrl_o.mem_rdn = 1'b0;
                ctrl_o.b_wrtn  = 1'b0;
            end
            S_STA: begin
                ctrl_o.a_rdn    = 1'b0;
                ctrl_o.mem_wrtn = 1'b0;
            end
            S_ALU: begin
                ctrl_o.alu_sel      = 1'b1;
                ctrl_o.alu_opcode   = operand_i;
                ctrl_o.a_wrtn       = 1'b0;
                ctrl_o.alu_flag_sel = 1'b1;
            end
            S_JA1: begin
                ctrl_o.mem_rdn = 1'b0;
                ctrl_o.pc_din  = 1'b1;
            end
            S_SKIP: ctrl_o.pc_cntn = 1'b0;
            default: ctrl_o = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: owns the state register, opcode latch, run gating
// and next-state logic; strobe values come from seq_decode.
module control_sequencer
    import cpu_8bit_pkg::*;
#(
    parameter bit ILLEGAL_HALT  = 1'b0,
    parameter bit HALT_ON_PC_OF = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic [7:0] i_instr,
    input  logic       i_zr,
    input  logic       i_ng,
    input  logic       i_co,
    input  logic       i_pc_of,
    output logic       o_a_wrtn,
    output logic       o_b_wrtn,
    output logic       o_ir_wrtn,
    output logic       o_mar_wrtn,
    output logic       o_a_rdn,
    output logic       o_b_rdn,
    output logic       o_ir_rdn,
    output logic       o_mar_rdn,
    output logic       o_mem_rdn,
    output logic       o_mem_wrtn,
    output logic       o_alu_sel,
    output logic       o_alu_flag_sel,
    output logic [3:0] o_alu_opcode,
    output logic       o_cin,
    output logic       o_pc_cntn,
    output logic       o_pc_den,
    output logic       o_pc_din,
    output logic       o_halted,
    output logic       o_fault,
    output logic       o_illegal
);

    seq_state_e state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] operand_q, operand_d;
    logic       fault_q, fault_d;
    logic       illegal;
    ctrl_word_t ctrl_raw, ctrl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH0;
            opcode_q  <= 4'd0;
            operand_q <= 4'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        fault_d   = fault_q;
        illegal   = 1'b0;
        if (i_run) begin
            unique case (state_q)
                S_FETCH0: begin
                    if (HALT_ON_PC_OF && i_pc_of) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_FETCH1;
                    end
                end
                S_FETCH1: state_d = S_DECODE;
                S_DECODE: begin
                    opcode_d  = i_instr[7:4];
                    operand_d = i_instr[3:0];
                    // The latch is not visible yet, so branch on the live IR byte.
                    case (opcode_e'(i_instr[7:4]))
                        OP_NOP:                state_d = S_FETCH0;
                        OP_LDA, OP_LDB, OP_STA: state_d = S_ADR0;
                        OP_ALU:                state_d = S_ALU;
                        OP_JMP:                state_d = S_JA0;
                        OP_JZ:                 state_d = i_zr ? S_JA0 : S_SKIP;
                        OP_JC:                 state_d = i_co ? S_JA0 : S_SKIP;
                        OP_JN:                 state_d = i_ng ? S_JA0 : S_SKIP;
                        OP_HLT:                state_d = S_HALT;
                        default: begin
                            illegal = 1'b1;
                            state_d = ILLEGAL_HALT ? S_HALT : S_FETCH0;
                        end
                    endcase
                end
                S_ADR0: state_d = S_ADR1;
                S_ADR1: begin
                    case (opcode_q)
                        OP_LDA:  state_d = S_MEMA;
                        OP_LDB:  state_d = S_MEMB;
                        default: state_d = S_STA;
                    endcase
                end
                S_JA0:  state_d = S_JA1;
                S_HALT: state_d = S_HALT;
                default: state_d = S_FETCH0;
            endcase
        end
    end

    seq_decode u_decode (
        .state_i   (state_q),
        .operand_i (operand_q),
        .ctrl_o    (ctrl_raw)
    );

    // Stalled or in reset: every strobe is forced to its inactive level.
    assign ctrl = (i_run && !i_rst) ? ctrl_raw : CTRL_IDLE;

    assign o_a_wrtn       = ctrl.a_wrtn;
    assign o_b_wrtn       = ctrl.b_wrtn;
    assign o_ir_wrtn      = ctrl.ir_wrtn;
    assign o_mar_wrtn     = ctrl.mar_wrtn;
    assign o_a_rdn        = ctrl.a_rdn;
    assign o_b_rdn        = ctrl.b_rdn;
    assign o_ir_rdn       = ctrl.ir_rdn;
    assign o_mar_rdn      = ctrl.mar_rdn;
    assign o_mem_rdn      = ctrl.mem_rdn;
    assign o_mem_wrtn     = ctrl.mem_wrtn;
    assign o_alu_sel      = ctrl.alu_sel;
    assign o_alu_flag_sel = ctrl.alu_flag_sel;
    assign o_alu_opcode   = ctrl.alu_opcode;
    assign o_cin          = ctrl.cin;
    assign o_pc_cntn      = ctrl.pc_cntn;
    assign o_pc_den       = ctrl.pc_den;
    assign o_pc_din       = ctrl.pc_din;
    assign o_halted       = !i_rst && (state_q == S_HALT);
    assign o_fault        = !i_rst && fault_q;
    assign o_illegal      = !i_rst && illegal;

    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert ($countones({ctrl.pc_den, ~ctrl.mem_rdn, ~ctrl.a_rdn, ~ctrl.b_rdn,
                                ~ctrl.ir_rdn, ~ctrl.mar_rdn, ctrl.alu_sel}) <= 1);
            assert (!(!ctrl.pc_cntn && ctrl.pc_din));
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction sequences queue their expected
// per-cycle control vectors; a negedge monitor pops and compares.
module tb_control_sequencer;

    typedef logic [22:0] vec_t;
    typedef struct {
        vec_t  v;
        string nm;
    } exp_t;

    localparam logic [14:0] AW   = 15'h0001;
    localparam logic [14:0] BW   = 15'h0002;
    localparam logic [14:0] IRW  = 15'h0004;
    localparam logic [14:0] MARW = 15'h0008;
    localparam logic [14:0] AR   = 15'h0010;
    localparam logic [14:0] MR   = 15'h0020;
    localparam logic [14:0] MWR  = 15'h0040;
    localparam logic [14:0] ASEL = 15'h0080;
    localparam logic [14:0] FSEL = 15'h0100;
    localparam logic [14:0] PCNT = 15'h0200;
    localparam logic [14:0] PDEN = 15'h0400;
    localparam logic [14:0] PDIN = 15'h0800;
    localparam logic [14:0] HLT  = 15'h1000;
    localparam logic [14:0] FLT  = 15'h2000;
    localparam logic [14:0] ILL  = 15'h4000;

    logic clk = 1'b0;
    logic i_rst, i_run, i_zr, i_ng, i_co, i_pc_of;
    logic [7:0] i_instr;
    logic o_a_wrtn, o_b_wrtn, o_ir_wrtn, o_mar_wrtn;
    logic o_a_rdn, o_b_rdn, o_ir_rdn, o_mar_rdn;
    logic o_mem_rdn, o_mem_wrtn, o_alu_sel, o_alu_flag_sel;
    logic [3:0] o_alu_opcode;
    logic o_cin, o_pc_cntn, o_pc_den, o_pc_din, o_halted, o_fault, o_illegal;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    exp_t item;
    vec_t dut_v;
    vec_t IDLE, F0, F1, ADR1, MEMA, MEMB, STA, ALU3, JA1, SKIP, HALT, HALTF, DECILL;

    always #5 clk = ~clk;

    control_sequencer dut (
        .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_instr(i_instr),
        .i_zr(i_zr), .i_ng(i_ng), .i_co(i_co), .i_pc_of(i_pc_of),
        .o_a_wrtn(o_a_wrtn), .o_b_wrtn(o_b_wrtn), .o_ir_wrtn(o_ir_wrtn), .o_mar_wrtn(o_mar_wrtn),
        .o_a_rdn(o_a_rdn), .o_b_rdn(o_b_rdn), .o_ir_rdn(o_ir_rdn), .o_mar_rdn(o_mar_rdn),
        .o_mem_rdn(o_mem_rdn), .o_mem_wrtn(o_mem_wrtn), .o_alu_sel(o_alu_sel),
        .o_alu_flag_sel(o_alu_flag_sel), .o_alu_opcode(o_alu_opcode), .o_cin(o_cin),
        .o_pc_cntn(o_pc_cntn), .o_pc_den(o_pc_den), .o_pc_din(o_pc_din),
        .o_halted(o_halted), .o_fault(o_fault), .o_illegal(o_illegal)
    );

    assign dut_v = {o_a_wrtn, o_b_wrtn, o_ir_wrtn, o_mar_wrtn,
                    o_a_rdn, o_b_rdn, o_ir_rdn, o_mar_rdn,
                    o_mem_rdn, o_mem_wrtn, o_alu_sel, o_alu_flag_sel,
                    o_alu_opcode, o_cin, o_pc_cntn, o_pc_den, o_pc_din,
                    o_halted, o_fault, o_illegal};

    // Active set given as flags; active-low strobes are inverted here.
    function automatic vec_t ev(input logic [14:0] m, input logic [3:0] op);
        return {~m[0], ~m[1], ~m[2], ~m[3], ~m[4], 1'b1, 1'b1, 1'b1,
                ~m[5], ~m[6], m[7], m[8], op, 1'b0,
                ~m[9], m[10], m[11], m[12], m[13], m[14]};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item = sb.pop_front();
            total++;
            if (dut_v !== item.v) begin
                bad++;
                $display("FAIL %s got=%h exp=%h t=%0t", item.nm, dut_v, item.v, $time);
            end
        end
    end

    task automatic cyc(input vec_t e, input string nm);
        exp_t x;
        x.v  = e;
        x.nm = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [7:0] ins, input vec_t dec, input string nm);
        i_instr = ins;
        cyc(F0, {nm, "_f0"});
        cyc(F1, {nm, "_f1"});
        cyc(dec, {nm, "_dec"});
    endtask

    initial begin
        IDLE   = ev(15'h0, 4'd0);
        F0     = ev(PDEN | MARW, 4'd0);
        F1     = ev(MR | IRW | PCNT, 4'd0);
        ADR1   = ev(MR | MARW | PCNT, 4'd0);
        MEMA   = ev(MR | AW, 4'd0);
        MEMB   = ev(MR | BW, 4'd0);
        STA    = ev(AR | MWR, 4'd0);
        ALU3   = ev(ASEL | FSEL | AW, 4'd3);
        JA1    = ev(MR | PDIN, 4'd0);
        SKIP   = ev(PCNT, 4'd0);
        HALT   = ev(HLT, 4'd0);
        HALTF  = ev(HLT | FLT, 4'd0);
        DECILL = ev(ILL, 4'd0);

        i_rst = 1'b1; i_run = 1'b1; i_instr = 8'h00;
        i_zr = 1'b0; i_ng = 1'b0; i_co = 1'b0; i_pc_of = 1'b0;
        @(posedge clk);
        #1;
        cyc(IDLE, "rst0");
        cyc(IDLE, "rst1");
        i_rst = 1'b0;

        fetch_decode(8'h00, IDLE, "nop1");
        fetch_decode(8'h00, IDLE, "nop2");

        fetch_decode(8'h10, IDLE, "lda");
        cyc(F0, "lda_adr0");
        cyc(ADR1, "lda_adr1");
        cyc(MEMA, "lda_mema");

        fetch_decode(8'h27, IDLE, "ldb");
        cyc(F0, "ldb_adr0");
        cyc(ADR1, "ldb_adr1");
        cyc(MEMB, "ldb_memb");

        fetch_decode(8'h30, IDLE, "sta");
        cyc(F0, "sta_adr0");
        cyc(ADR1, "sta_adr1");
        cyc(STA, "sta_sta");

        fetch_decode(8'h43, IDLE, "alu");
        cyc(ALU3, "alu_exec");

        fetch_decode(8'h50, IDLE, "jmp");
        cyc(F0, "jmp_ja0");
        cyc(JA1, "jmp_ja1");

        i_zr = 1'b1;
        fetch_decode(8'h60, IDLE, "jz_t");
        i_zr = 1'b0;
        cyc(F0, "jz_t_ja0");
        cyc(JA1, "jz_t_ja1");

        fetch_decode(8'h60, IDLE, "jz_n");
        cyc(SKIP, "jz_n_skip");

        i_co = 1'b1;
        fetch_decode(8'h70, IDLE, "jc_t");
        i_co = 1'b0;
        cyc(F0, "jc_t_ja0");
        cyc(JA1, "jc_t_ja1");

        i_zr = 1'b1; i_co = 1'b1;
        fetch_decode(8'h80, IDLE, "jn_n");
        cyc(SKIP, "jn_n_skip");
        i_zr = 1'b0; i_co = 1'b0;

        fetch_decode(8'h9A, DECILL, "ill");

        fetch_decode(8'h10, IDLE, "stall");
        cyc(F0, "stall_adr0");
        i_run = 1'b0;
        cyc(IDLE, "stall_idle0");
        cyc(IDLE, "stall_idle1");
        cyc(IDLE, "stall_idle2");
        i_run = 1'b1;
        cyc(ADR1, "stall_adr1");
        cyc(MEMA, "stall_mema");

        fetch_decode(8'hF0, IDLE, "hlt");
        i_instr = 8'h10;
        cyc(HALT, "halt0");
        cyc(HALT, "halt1");
        cyc(HALT, "halt2");
        i_rst = 1'b1;
        cyc(IDLE, "halt_rst");
        i_rst = 1'b0;
        i_instr = 8'h00;
        cyc(F0, "halt_post_f0");
        cyc(F1, "halt_post_f1");
        cyc(IDLE, "halt_post_dec");

        i_pc_of = 1'b1;
        cyc(F0, "pcof_f0");
        i_pc_of = 1'b0;
        cyc(HALTF, "pcof_halt0");
        cyc(HALTF, "pcof_halt1");
        i_rst = 1'b1;
        cyc(IDLE, "pcof_rst");
        i_rst = 1'b0;
        cyc(F0, "pcof_post_f0");

        for (int k = 0; k < 400; k++) begin
            i_instr = 8'($urandom);
            i_zr    = 1'($urandom);
            i_co    = 1'($urandom);
            i_ng    = 1'($urandom);
            i_run   = ($urandom_range(0, 3) != 0);
            i_rst   = o_halted;
            @(posedge clk);
            #1;
        end

        i_rst = 1'b1; i_run = 1'b1; i_instr = 8'h00;
        cyc(IDLE, "final_rst");
        i_rst = 1'b0;
        cyc(F0, "final_f0");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
